// File: rtl/user_req_responder.sv
// user_req_responder: target for the U_* request interface, serving strobed writes
// and wrapping burst reads from a local register bank.
module user_req_responder #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        U_WVALID,
    input  logic [31:0] U_AWADDR,
    input  logic [31:0] U_WDATA,
    input  logic [3:0]  U_STRB,
    input  logic        U_RVALID,
    input  logic [31:0] U_ARADDR,
    input  logic [3:0]  U_BLEN,
    output logic [31:0] U_RDATA,
    output logic        U_RDVALID,
    output logic        U_RLAST,
    output logic        U_BVALID,
    output logic        U_BUSY,
    output logic        U_DROP
);
    typedef enum logic {IDLE, READ} state_t;
    state_t        state;
    logic [31:0]   bank [DEPTH];
    logic [AW-1:0] idx;
    logic [3:0]    cnt;
    logic [AW-1:0] widx;
    logic          unused_addr_bits;
    // byte offset and high address bits alias the bank
    assign widx = U_AWADDR[AW+1:2];
    assign unused_addr_bits = ^{U_AWADDR[31:AW+2], U_AWADDR[1:0], U_ARADDR[31:AW+2], U_ARADDR[1:0]};
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            U_RDATA   <= '0;
            U_RDVALID <= 1'b0;
            U_RLAST   <= 1'b0;
            U_BVALID  <= 1'b0;
            U_BUSY    <= 1'b0;
            U_DROP    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else begin
            U_RDVALID <= 1'b0;
            U_RLAST   <= 1'b0;
            U_BVALID  <= 1'b0;
            if (state == IDLE) begin
                U_BVALID <= U_WVALID;
                U_DROP   <= U_WVALID && U_RVALID;
                U_BUSY   <= U_RVALID && !U_WVALID;
                if (U_WVALID) begin
                    for (int b = 0; b < 4; b++)
                        if (U_STRB[b]) bank[widx][8*b +: 8] <= U_WDATA[8*b +: 8];
                end else if (U_RVALID) begin
                    idx   <= U_ARADDR[AW+1:2];
                    cnt   <= U_BLEN;
                    state <= READ;
                end
            end else begin
                U_DROP    <= U_WVALID || U_RVALID;
                U_RDATA   <= bank[idx];
                U_RDVALID <= 1'b1;
                idx       <= idx + 1'b1;
                cnt       <= cnt - 1'b1;
                if (cnt == '0) begin
                    U_RLAST <= 1'b1;
                    state   <= IDLE;
                end
            end
        end
    end
endmodule
